axil_register_slave: RTL
========================

// Module: axil_register_slave
// PURPOSE
//  AXI4-Lite slave register bank; terminates one master port of the AXI-Lite interconnect.
//  Holds NUM_CTRL read/write control registers, exposes NUM_STATUS read-only status words.
//  Drives the control words and per-register write pulses into DMA datapath logic.
//  Decodes a 4 KiB window (addr[11:2]); the interconnect has already selected the base.
// PARAMETERS
//  NUM_CTRL    8   number of R/W control registers, word index 0..NUM_CTRL-1
//  NUM_STATUS  8   number of RO status words, index NUM_CTRL..NUM_CTRL+NUM_STATUS-1
//  CTRL_RESET  0   32-bit reset value loaded into every control register
// PORTS
//  aclk            in   1              clock, all logic rising-edge
//  aresetn         in   1              asynchronous, active-low reset
//  s_axil_aw*      in/out  32/3/1/1    awaddr, awprot (ignored), awvalid, awready
//  s_axil_w*       in/out  32/4/1/1    wdata, wstrb, wvalid, wready
//  s_axil_b*       out/in  2/1/1       bresp, bvalid, bready
//  s_axil_ar*      in/out  32/3/1/1    araddr, arprot (ignored), arvalid, arready
//  s_axil_r*       out/in  32/2/1/1    rdata, rresp, rvalid, rready
//  ctrl_regs       out  NUM_CTRL*32    control word i at [i*32 +: 32]
//  ctrl_wr_pulse   out  NUM_CTRL       1-cycle pulse on commit of a write to register i
//  status_in       in   NUM_STATUS*32  status word j at [j*32 +: 32], sampled on read
// BEHAVIOUR
//  Reset (aresetn=0, async): ctrl_regs=CTRL_RESET; awready=wready=arready=0;
//   bvalid=rvalid=0; bresp=rresp=0; rdata=0; ctrl_wr_pulse=0. Pending transactions dropped.
//   awready/wready/arready rise in the first cycle after reset deassertion.
//  Write FSM W_IDLE -> W_RESP:
//   W_IDLE: awready=1 while no address held, wready=1 while no data held; AW and W
//    are captured independently, in either order or the same cycle.
//   When both are held: the write commits at the next edge; FSM enters W_RESP.
//   W_RESP: bvalid=1 with bresp held stable until bready; awready=wready=0.
//    On the bvalid&&bready edge: return to W_IDLE, holding flags cleared.
//   Commit: idx=awaddr[11:2]. For idx<NUM_CTRL: byte k is written iff wstrb[k];
//    ctrl_wr_pulse[idx]=1 in the cycle bvalid first rises (also for wstrb=0); bresp=OKAY(2'b00).
//    For idx>=NUM_CTRL: no register changes, no pulse, bresp=SLVERR(2'b10).
//   Latency: AW+W in cycle 0 -> register value and bvalid visible in cycle 1.
//  Read FSM R_IDLE -> R_DATA:
//   R_IDLE: arready=1. On arvalid, rdata/rresp are registered at the same edge;
//    FSM enters R_DATA. R_DATA: rvalid=1, arready=0, rdata/rresp stable until rready.
//   idx<NUM_CTRL: rdata=ctrl word, OKAY. NUM_CTRL<=idx<NUM_CTRL+NUM_STATUS:
//    rdata=status_in word idx-NUM_CTRL, OKAY. Otherwise rdata=0, SLVERR.
//   Latency: arvalid in cycle 0 -> rvalid in cycle 1; one outstanding read max.
//  Read and write FSMs are independent. A read sampled on the same edge as a write
//   commit to the same register returns the pre-write value.
//  addr[1:0] and addr[31:12] are ignored; no aliasing checks beyond bit 11.
// TESTING
//  1. Reset, then AW=0x004 + W=0xDEADBEEF, wstrb=0xF same cycle -> bvalid in cycle 1,
//     bresp=00, ctrl word1=0xDEADBEEF, ctrl_wr_pulse=8'h02 for exactly 1 cycle.
//  2. W first (0x11223344, wstrb=0x5), AW 0x008 three cycles later, word2 was
//     0xFFFFFFFF -> word2=0xFF22FF44, bvalid asserted once after AW.
//  3. Read 0x020 (idx 8) with status_in word0=0xCAFE0001 -> rvalid next cycle,
//     rdata=0xCAFE0001, rresp=00; hold rready=0 for 5 cycles -> rdata stable, arready=0.
//  4. Write 0x020 and read 0x400 -> bresp=10 with no register change or pulse;
//     rresp=10, rdata=0.
//  5. Same-cycle commit to word0 (0x0->0xA5) and read of word0 -> rdata=0x0;
//     a following read -> 0xA5.
//  6. Assert aresetn low while bvalid=1 and rvalid=1 -> both drop immediately,
//     ctrl_regs=CTRL_RESET; after release a new write completes normally.

Source files
------------

// File: rtl/axil_register_slave.sv
// AXI4-Lite slave register bank.
//
// Holds NUM_CTRL read/write control words and exposes NUM_STATUS read-only status words.
// The block decodes a 4 KiB window using addr[11:2]. Bits [1:0] and [31:12] are ignored.
//
// Ports:
//   aclk_i, aresetn_i       clock (rising edge) and asynchronous active-low reset
//   s_axil_aw*/w*/b*        AXI-Lite write address, write data and write response channels
//   s_axil_ar*/r*           AXI-Lite read address and read data channels
//   ctrl_regs_o             control word i at [i*32 +: 32]
//   ctrl_wr_pulse_o         one-cycle pulse per register, asserted alongside the first bvalid cycle
//   status_in_i             status word j at [j*32 +: 32], sampled when a read is accepted
module axil_register_slave #(
  parameter int unsigned NUM_CTRL   = 8,
  parameter int unsigned NUM_STATUS = 8,
  parameter logic [31:0] CTRL_RESET = 32'h0
) (
  input  logic                     aclk_i,
  input  logic                     aresetn_i,
  // Write address channel
  input  logic [31:0]              s_axil_awaddr_i,
  input  logic [2:0]               s_axil_awprot_i,
  input  logic                     s_axil_awvalid_i,
  output logic                     s_axil_awready_o,
  // Write data channel
  input  logic [31:0]              s_axil_wdata_i,
  input  logic [3:0]               s_axil_wstrb_i,
  input  logic                     s_axil_wvalid_i,
  output logic                     s_axil_wready_o,
  // Write response channel
  output logic [1:0]               s_axil_bresp_o,
  output logic                     s_axil_bvalid_o,
  input  logic                     s_axil_bready_i,
  // Read address channel
  input  logic [31:0]              s_axil_araddr_i,
  input  logic [2:0]               s_axil_arprot_i,
  input  logic                     s_axil_arvalid_i,
  output logic                     s_axil_arready_o,
  // Read data channel
  output logic [31:0]              s_axil_rdata_o,
  output logic [1:0]               s_axil_rresp_o,
  output logic                     s_axil_rvalid_o,
  input  logic                     s_axil_rready_i,
  // Datapath side
  output logic [NUM_CTRL*32-1:0]   ctrl_regs_o,
  output logic [NUM_CTRL-1:0]      ctrl_wr_pulse_o,
  input  logic [NUM_STATUS*32-1:0] status_in_i
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [0:0] {StWIdle, StWResp} wstate_e;
  typedef enum logic [0:0] {StRIdle, StRData} rstate_e;

  // ---------------------------------------------------------------------------
  // Shared storage
  // ---------------------------------------------------------------------------
  logic [NUM_CTRL-1:0][31:0]   ctrl_q, ctrl_d;
  logic [NUM_STATUS-1:0][31:0] status_words;

  assign status_words = status_in_i;
  assign ctrl_regs_o  = ctrl_q;

  // Protection bits and out-of-window address bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{s_axil_awprot_i, s_axil_arprot_i,
                         s_axil_awaddr_i[31:12], s_axil_awaddr_i[1:0],
                         s_axil_araddr_i[31:12], s_axil_araddr_i[1:0]};

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  wstate_e             wstate_q, wstate_d;
  logic                aw_held_q, aw_held_d;
  logic                w_held_q, w_held_d;
  logic [9:0]          awidx_q, awidx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [NUM_CTRL-1:0] pulse_q, pulse_d;

  logic                aw_hs, w_hs;
  logic [31:0]         wr_idx;
  logic [31:0]         wr_data;
  logic [3:0]          wr_strb;
  logic [NUM_CTRL-1:0] wr_sel;
  logic                wr_hit;

  // Readies are registered and only asserted in idle, so a handshake implies idle.
  assign aw_hs = s_axil_awvalid_i & awready_q;
  assign w_hs  = s_axil_wvalid_i & wready_q;

  // Commit operands come from the holding registers, or straight from the bus when
  // the channel is handshaking on the same edge as the commit.
  assign wr_idx  = {22'b0, (aw_held_q ? awidx_q : s_axil_awaddr_i[11:2])};
  assign wr_data = w_held_q ? wdata_q : s_axil_wdata_i;
  assign wr_strb = w_held_q ? wstrb_q : s_axil_wstrb_i;

  always_comb begin
    wr_sel = '0;
    wr_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_CTRL; i++) begin
      if (wr_idx == i) begin
        wr_sel[i] = 1'b1;
        wr_hit    = 1'b1;
      end
    end
  end

  always_comb begin
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awidx_d   = awidx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    pulse_d   = '0;
    ctrl_d    = ctrl_q;

    unique case (wstate_q)
      StWIdle: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awidx_d   = s_axil_awaddr_i[11:2];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s_axil_wdata_i;
          wstrb_d  = s_axil_wstrb_i;
        end
        if (aw_held_d && w_held_d) begin
          wstate_d  = StWResp;
          bvalid_d  = 1'b1;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          if (wr_hit) begin
            bresp_d = RespOkay;
            pulse_d = wr_sel;
            for (int unsigned i = 0; i < NUM_CTRL; i++) begin
              if (wr_sel[i]) begin
                for (int k = 0; k < 4; k++) begin
                  if (wr_strb[k]) ctrl_d[i][8*k +: 8] = wr_data[8*k +: 8];
                end
              end
            end
          end else begin
            bresp_d = RespSlvErr;
          end
        end else begin
          awready_d = ~aw_held_d;
          wready_d  = ~w_held_d;
        end
      end
      StWResp: begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        if (s_axil_bready_i) begin
          wstate_d  = StWIdle;
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: wstate_d = StWIdle;
    endcase
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      wstate_q  <= StWIdle;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      pulse_q   <= '0;
      ctrl_q    <= {NUM_CTRL{CTRL_RESET}};
    end else begin
      wstate_q  <= wstate_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awidx_q   <= awidx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      pulse_q   <= pulse_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign s_axil_awready_o = awready_q;
  assign s_axil_wready_o  = wready_q;
  assign s_axil_bvalid_o  = bvalid_q;
  assign s_axil_bresp_o   = bresp_q;
  assign ctrl_wr_pulse_o  = pulse_q;

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  rstate_e     rstate_q, rstate_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  logic [31:0] rd_idx;
  logic [31:0] rd_word;
  logic [1:0]  rd_resp;

  assign rd_idx = {22'b0, s_axil_araddr_i[11:2]};

  // Lookup uses ctrl_q, so a read accepted on a commit edge returns the old value.
  always_comb begin
    rd_word = '0;
    rd_resp = RespSlvErr;
    for (int unsigned i = 0; i < NUM_CTRL; i++) begin
      if (rd_idx == i) begin
        rd_word = ctrl_q[i];
        rd_resp = RespOkay;
      end
    end
    for (int unsigned j = 0; j < NUM_STATUS; j++) begin
      if (rd_idx == NUM_CTRL + j) begin
        rd_word = status_words[j];
        rd_resp = RespOkay;
      end
    end
  end

  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    unique case (rstate_q)
      StRIdle: begin
        if (s_axil_arvalid_i && arready_q) begin
          rstate_d  = StRData;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = rd_word;
          rresp_d   = rd_resp;
        end else begin
          arready_d = 1'b1;
        end
      end
      StRData: begin
        arready_d = 1'b0;
        if (s_axil_rready_i) begin
          rstate_d  = StRIdle;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: rstate_d = StRIdle;
    endcase
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      rstate_q  <= StRIdle;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_axil_arready_o = arready_q;
  assign s_axil_rvalid_o  = rvalid_q;
  assign s_axil_rdata_o   = rdata_q;
  assign s_axil_rresp_o   = rresp_q;

endmodule
